mem_stage_access: RTL and testbench

- MEM-stage responder for the memory request carried in the EX/MEM pipeline register outputs: MemRead/MemWrite control, ALU address, store data.
- Turns each load/store into a req/ack transaction on a variable-latency data-memory bus.
- Holds the pipeline with stall_m until the access completes, then presents the load data to MEM/WB.
- Flags misaligned accesses, illegal control, and bus timeouts.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/mem_stage_access.sv | 136 +++++++++++++
 tb/tb_mem_stage_access.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared MEM-stage field positions, error codes and FSM states
package pipeline_pkg;

  localparam int MEM_READ_BIT  = 1;
  localparam int MEM_WRITE_BIT = 0;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } mem_state_e;

endpackage

// File: rtl/mem_stage_access.sv
// rtl/mem_stage_access.sv - MEM-stage load/store responder on a req/ack data-memory bus
module mem_stage_access
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mem_ctl_m,
  input  logic [ADDR_W-1:0] alu_out_m,
  input  logic [DATA_W-1:0] write_data_m,
  output logic              stall_m,
  output logic [DATA_W-1:0] read_data_m,
  output logic              done_m,
  output logic [1:0]        err_m,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;

  logic op, illegal, misaligned;

  assign op         = |mem_ctl_m;
  assign illegal    = &mem_ctl_m;
  assign misaligned = |alu_out_m[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    stall_m = 1'b0;
    done_m  = 1'b0;
    err_m   = ERR_OK;

    case (state_q)
      ST_IDLE: begin
        // rst_n gates the combinational stall so it also drops during reset
        stall_m = op & rst_n;
        if (op) begin
          if (illegal) begin
            err_d   = ERR_ILLEGAL;
            rdata_d = '0;
            state_d = ST_DONE;
          end else if (misaligned) begin
            err_d   = ERR_MISALIGN;
            rdata_d = '0;
            state_d = ST_DONE;
          end else begin
            addr_d  = {alu_out_m[ADDR_W-1:2], 2'b00};
            we_d    = mem_ctl_m[MEM_WRITE_BIT];
            wdata_d = write_data_m;
            req_d   = 1'b1;
            count_d = '0;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall_m = rst_n;
        // ack is checked first so it wins over a simultaneous timeout
        if (mem_ack) begin
          req_d   = 1'b0;
          rdata_d = we_q ? '0 : mem_rdata;
          err_d   = ERR_OK;
          state_d = ST_DONE;
        end else if (count_q == CNT_LAST) begin
          req_d   = 1'b0;
          rdata_d = '0;
          err_d   = ERR_TIMEOUT;
          state_d = ST_DONE;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        done_m  = 1'b1;
        err_m   = err_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign read_data_m = rdata_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// tb/tb_mem_stage_access.sv - randomized and directed bench for mem_stage_access
module tb_mem_stage_access;

  typedef struct {
    logic [1:0]  err;
    logic [31:0] rd;
    int          reqc;
    int          stallc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic [1:0]  ctl   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdat  [2];
  logic [31:0] rdat  [2];
  logic        ack   [2];
  logic        stall [2];
  logic        done  [2];
  logic [1:0]  err   [2];
  logic [31:0] rd    [2];
  logic        req   [2];
  logic        we    [2];
  logic [31:0] maddr [2];
  logic [31:0] mwd   [2];
  logic [31:0] last_rd [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_stage_access #(.TIMEOUT_CYCLES(16), .ADDR_W(32), .DATA_W(32)) dut16 (
    .clk(clk), .rst_n(rst_n[0]), .mem_ctl_m(ctl[0]), .alu_out_m(addr[0]),
    .write_data_m(wdat[0]), .stall_m(stall[0]), .read_data_m(rd[0]), .done_m(done[0]),
    .err_m(err[0]), .mem_req(req[0]), .mem_we(we[0]), .mem_addr(maddr[0]),
    .mem_wdata(mwd[0]), .mem_ack(ack[0]), .mem_rdata(rdat[0])
  );

  mem_stage_access #(.TIMEOUT_CYCLES(4), .ADDR_W(32), .DATA_W(32)) dut4 (
    .clk(clk), .rst_n(rst_n[1]), .mem_ctl_m(ctl[1]), .alu_out_m(addr[1]),
    .write_data_m(wdat[1]), .stall_m(stall[1]), .read_data_m(rd[1]), .done_m(done[1]),
    .err_m(err[1]), .mem_req(req[1]), .mem_we(we[1]), .mem_addr(maddr[1]),
    .mem_wdata(mwd[1]), .mem_ack(ack[1]), .mem_rdata(rdat[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%h expected=0x%h", tag, got, exp);
    end
  endtask

  function automatic int timeout_of(input int k);
    return (k == 0) ? 16 : 4;
  endfunction

  // Transaction-level outcome: wait_n = idle cycles before ack, -1 = never acked
  function automatic exp_t model(input int to, input logic [1:0] c, input logic [31:0] a,
                                 input logic [31:0] rdv, input int wait_n);
    exp_t e;
    if (c == 2'b11) begin
      e.err = 2'b11; e.rd = 0; e.reqc = 0; e.stallc = 1;
    end else if (a % 4 != 0) begin
      e.err = 2'b01; e.rd = 0; e.reqc = 0; e.stallc = 1;
    end else if (wait_n < 0 || wait_n >= to) begin
      e.err = 2'b10; e.rd = 0; e.reqc = to; e.stallc = to + 1;
    end else begin
      e.err = 2'b00; e.rd = (c == 2'b10) ? rdv : 32'h0;
      e.reqc = wait_n + 1; e.stallc = wait_n + 2;
    end
    return e;
  endfunction

  task automatic run_txn(input int k, input logic [1:0] c, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdv, input int wait_n,
                         output int done_cyc, output int req_start);
    exp_t e;
    int r, s, bad;
    bit got;
    e = model(timeout_of(k), c, a, rdv, wait_n);
    r = 0; s = 0; bad = 0; got = 0; done_cyc = -1; req_start = -1;
    @(negedge clk);
    ctl[k] = c; addr[k] = a; wdat[k] = wd; rdat[k] = rdv; ack[k] = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (n > 0) @(negedge clk);
      if (req[k]) begin
        r++;
        if (r == 1) req_start = cyc;
        if (maddr[k] !== (a & 32'hFFFF_FFFC) || we[k] !== c[0] || mwd[k] !== wd) bad++;
        ack[k] = (wait_n >= 0 && r == wait_n + 1);
      end else begin
        ack[k] = 1'b0;
      end
      #1;
      if (stall[k]) s++;
      if (done[k]) begin
        got = 1;
        done_cyc = cyc;
        break;
      end
    end
    check("done_seen", 32'(got), 32'd1);
    check("err", 32'(err[k]), 32'(e.err));
    check("read_data", rd[k], e.rd);
    check("req_cycles", r, e.reqc);
    check("stall_cycles", s, e.stallc);
    check("bus_stable", bad, 0);
    last_rd[k] = e.rd;
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    ctl[k] = 2'b00; ack[k] = 1'b0;
    #1;
    check("idle_stall", 32'(stall[k]), 0);
    check("idle_done", 32'(done[k]), 0);
    check("idle_req", 32'(req[k]), 0);
    check("rd_hold", rd[k], last_rd[k]);
  endtask

  initial begin
    int d1, q1, d2, q2, cc, w, rr;
    logic [31:0] a;
    bit spur;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; ctl[k] = 2'b00; addr[k] = 0; wdat[k] = 0;
      rdat[k] = 0; ack[k] = 1'b0; last_rd[k] = 0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_stall", 32'(stall[k]), 0);
      check("rst_done", 32'(done[k]), 0);
      check("rst_err", 32'(err[k]), 0);
      check("rst_rd", rd[k], 0);
      check("rst_req", 32'(req[k]), 0);
      check("rst_we", 32'(we[k]), 0);
      check("rst_addr", maddr[k], 0);
      check("rst_wdata", mwd[k], 0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    run_txn(0, 2'b10, 32'h100, 32'h0, 32'hDEADBEEF, 0, d1, q1);
    idle(0);
    run_txn(0, 2'b01, 32'h204, 32'h12345678, 32'h5555AAAA, 4, d1, q1);
    idle(0);
    run_txn(0, 2'b10, 32'h102, 32'h0, 32'hFFFFFFFF, 0, d1, q1);
    idle(0);
    run_txn(0, 2'b11, 32'h300, 32'h1, 32'hFFFFFFFF, 0, d1, q1);
    idle(0);

    run_txn(1, 2'b10, 32'h40, 32'h0, 32'hCAFEF00D, -1, d1, q1);
    idle(1);
    run_txn(1, 2'b10, 32'h44, 32'h0, 32'hCAFEF00D, 3, d1, q1);
    idle(1);
    run_txn(1, 2'b01, 32'h48, 32'hA5A5A5A5, 32'h0, 4, d1, q1);
    idle(1);

    run_txn(0, 2'b10, 32'h400, 32'h0, 32'h11112222, 1, d1, q1);
    run_txn(0, 2'b01, 32'h404, 32'h33334444, 32'h0, 2, d2, q2);
    check("b2b_gap", q2 - d1, 2);
    idle(0);

    @(negedge clk);
    ctl[1] = 2'b10; addr[1] = 32'h80; ack[1] = 1'b0;
    @(negedge clk);
    check("pre_rst_req", 32'(req[1]), 1);
    @(negedge clk);
    #2 rst_n[1] = 1'b0;
    #1;
    check("async_req", 32'(req[1]), 0);
    check("async_stall", 32'(stall[1]), 0);
    check("async_done", 32'(done[1]), 0);
    ack[1] = 1'b1; rdat[1] = 32'hBAD0BAD0;
    @(negedge clk);
    ctl[1] = 2'b00;
    rst_n[1] = 1'b1;
    spur = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      #1;
      if (done[1] || req[1] || stall[1]) spur = 1;
      ack[1] = 1'b0;
    end
    check("post_rst_quiet", 32'(spur), 0);
    check("post_rst_rd", rd[1], 0);
    last_rd[1] = 0;
    run_txn(1, 2'b10, 32'h84, 32'h0, 32'h0BADCAFE, 0, d1, q1);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      rr = $urandom_range(0, 9);
      cc = (rr < 4) ? 2 : (rr < 8) ? 1 : 3;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
      w = $urandom_range(0, 19);
      if (w == 19) w = -1;
      run_txn(0, 2'(cc), a, $urandom, $urandom, w, d1, q1);
      if ($urandom_range(0, 1) == 1) idle(0);
    end
    idle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
